vga_video_receiver: RTL and testbench
=====================================

# vga_video_receiver

Sync-decoding capture block for the ADV7123-style parallel video interface. It samples HSync, VSync, nBlank and RGB565 pixels on the video clock and measures line and frame geometry. It tracks lock to a stable timing and emits a coordinate-tagged pixel stream for a capture/framebuffer writer. It is the loopback/capture counterpart used to check and record what the VGA driver puts on the pins.

## Interface
Parameters:
- MaxHTotal, 1024: largest supported clocks per line; HW = $clog2(MaxHTotal+1).
- MaxVTotal, 1024: largest supported lines per frame; VW = $clog2(MaxVTotal+1).
- LockFrames, 2: consecutive matching frames required to lock (≥1).
- HTimeout, 2048: clocks without an HSync rising edge before forced unlock.

Ports:
- i_VidClk  in  1  video clock; the only clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_HSync  in  1  horizontal sync, active high.
- i_VSync  in  1  vertical sync, active high.
- i_nBlank  in  1  high during active pixels.
- i_R  in  5  red. i_G  in  6  green. i_B  in  5  blue.
- o_PixValid  out  1  pixel on o_PixData is valid (locked only).
- o_PixData  out  16  {R,G,B} RGB565.
- o_PixX  out  HW  active-pixel column, 0-based.
- o_PixY  out  VW  active-line row, 0-based.
- o_FrameStart  out  1  with first valid pixel of a frame (X=0,Y=0).
- o_LineStart  out  1  with first valid pixel of each line (X=0).
- o_Locked  out  1  timing lock status.
- o_HTotal  out  HW  last measured clocks per line.
- o_HActive  out  HW  last measured active pixels per line.
- o_VTotal  out  VW  last measured lines per frame.
- o_VActive  out  VW  last measured active lines per frame.

## Operation
- All inputs registered once (stage S1); edges detected on S1 vs. previous S1.
- H counter: resets to 1 on HSync rising edge, else increments, saturating at MaxHTotal. On each HSync rising edge, the previous count goes into o_HTotal. The count of nBlank-high cycles in the finished line goes into o_HActive when nonzero.
- V counter: increments on each HSync rising edge and resets to 0 on VSync rising edge. On VSync rising edge it is latched into o_VTotal, and the count of lines containing ≥1 active pixel goes into o_VActive. Saturates at MaxVTotal.
- Pixel X: 0 at nBlank rising edge, +1 per active cycle. Pixel Y: 0 for first active line after VSync rising edge, +1 at each subsequent nBlank rising edge.
- Lock FSM, states UNLOCKED, ACQUIRE, LOCKED:
  - UNLOCKED: first VSync rising edge → ACQUIRE, match count = 0.
  - ACQUIRE: at each VSync rising edge, compare new {HTotal,HActive,VTotal,VActive} with the previously latched set.
    - Equal: increment the match count; reaching LockFrames → LOCKED.
    - Unequal: reset the match count to 0 and stay in ACQUIRE.
  - LOCKED: any mismatch at a VSync rising edge → ACQUIRE. Any mid-frame HSync rising edge whose line length ≠ o_HTotal → ACQUIRE.
  - Any state: HTimeout clocks without an HSync rising edge → UNLOCKED.
- Output: o_PixValid = S1 nBlank && LOCKED. Pixels in a frame where lock is lost are dropped from that cycle onward. o_Locked is high only in LOCKED.
- Frame start requires Y=0 and X=0. If lock is gained mid-frame, output begins at the next frame's first pixel. o_PixValid is suppressed until then.

## Timing
- Input sampled at rising edge k (S1) → o_Pix*, o_FrameStart, o_LineStart registered at edge k+1. Latency is 2 edges from pin change to output.
- Measurement outputs update at edge k+1 after the sync edge is seen in S1. o_Locked updates in the same cycle as the measurements that cause it.
- Reset (asynchronous, any time, including mid-frame): all outputs 0, FSM UNLOCKED, counters and match count 0. After release, capture resumes only after a fresh lock.
- Simultaneous HSync and VSync rising edges: the line is counted first, then V resets. Both latches use the pre-reset values.
- Saturated H or V counters are forced mismatches, which stops lock.

## Test plan
- Standard 640x480 stimulus with HTotal 800 and VTotal 525, 3 frames → o_Locked rises at the 3rd VSync edge. Measurements read 800/640/525/480.
- Locked frame → exactly 640×480 o_PixValid pulses. Frame data: X 0..639 and Y 0..479, one o_FrameStart, 480 o_LineStart, with RGB565 passed through 2 edges later.
- Change one line to 801 clocks while locked → o_Locked falls at that HSync edge and o_PixValid goes low. Relock follows after 2 clean frames.
- Hold HSync low for 2048 clocks → FSM UNLOCKED and o_Locked = 0. Restarting syncs requires ≥3 VSync edges to relock.
- Assert i_Reset mid-line at pixel X=300 → all outputs 0 asynchronously. After release, no o_PixValid until lock is re-established and a new frame starts.
- Apply HSync and VSync rising edges on the same cycle → o_VTotal includes that line, and the next line is Y/V index 0.

Source files
------------

// File: rtl/vga_video_receiver.sv
// Parallel RGB565 video capture: sync decoding, geometry measurement,
// lock tracking and coordinate-tagged pixel output.
module vga_video_receiver #(
  parameter int MaxHTotal  = 1024,
  parameter int MaxVTotal  = 1024,
  parameter int LockFrames = 2,
  parameter int HTimeout   = 2048,
  localparam int HW = $clog2(MaxHTotal + 1),
  localparam int VW = $clog2(MaxVTotal + 1)
) (
  input  logic          i_VidClk,
  input  logic          i_Reset,
  input  logic          i_HSync,
  input  logic          i_VSync,
  input  logic          i_nBlank,
  input  logic [4:0]    i_R,
  input  logic [5:0]    i_G,
  input  logic [4:0]    i_B,
  output logic          o_PixValid,
  output logic [15:0]   o_PixData,
  output logic [HW-1:0] o_PixX,
  output logic [VW-1:0] o_PixY,
  output logic          o_FrameStart,
  output logic          o_LineStart,
  output logic          o_Locked,
  output logic [HW-1:0] o_HTotal,
  output logic [HW-1:0] o_HActive,
  output logic [VW-1:0] o_VTotal,
  output logic [VW-1:0] o_VActive
);

  localparam int TW = $clog2(HTimeout + 1);
  localparam int MW = $clog2(LockFrames + 1);
  localparam int SW = 2 * HW + 2 * VW;
  localparam logic [HW-1:0] HMAX  = HW'(MaxHTotal);
  localparam logic [VW-1:0] VMAX  = VW'(MaxVTotal);
  localparam logic [TW-1:0] TOMAX = TW'(HTimeout - 1);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t r_State, w_StateNxt;
  logic [MW-1:0] r_Match, w_MatchNxt;

  logic r_HS, r_VS, r_NB, r_HSd, r_VSd, r_NBd;
  logic [15:0] r_Rgb;
  logic [HW-1:0] r_HCnt, r_HAct, r_XCnt;
  logic [VW-1:0] r_VCnt, r_VAct, r_YCnt;
  logic [TW-1:0] r_TO;
  logic r_LineAct, r_Dirty, r_SnapOk, r_First, r_Run;
  logic [SW-1:0] r_Snap;

  logic w_HRise, w_VRise, w_NBRise, w_Sat, w_LineBad;
  logic w_TimeOut, w_Equal, w_Start, w_NextLocked, w_Valid;
  logic [HW-1:0] w_HTotNew, w_HActNew, w_X;
  logic [VW-1:0] w_VTotNew, w_VActNew, w_VInc, w_Y;
  logic [SW-1:0] w_NewSet;

  assign w_HRise  = r_HS & ~r_HSd;
  assign w_VRise  = r_VS & ~r_VSd;
  assign w_NBRise = r_NB & ~r_NBd;

  always_ff @(posedge i_VidClk or posedge i_Reset) begin
    if (i_Reset) begin
      r_HS  <= 1'b0;
      r_VS  <= 1'b0;
      r_NB  <= 1'b0;
      r_HSd <= 1'b0;
      r_VSd <= 1'b0;
      r_NBd <= 1'b0;
      r_Rgb <= '0;
    end else begin
      r_HS  <= i_HSync;
      r_VS  <= i_VSync;
      r_NB  <= i_nBlank;
      r_HSd <= r_HS;
      r_VSd <= r_VS;
      r_NBd <= r_NB;
      r_Rgb <= {i_R, i_G, i_B};
    end
  end

  // A line closing at the VSync edge counts toward the frame being latched.
  assign w_VInc    = (r_VCnt == VMAX) ? r_VCnt : r_VCnt + VW'(1);
  assign w_HTotNew = w_HRise ? r_HCnt : o_HTotal;
  assign w_HActNew = (w_HRise && r_HAct != '0) ? r_HAct : o_HActive;
  assign w_VTotNew = w_HRise ? w_VInc : r_VCnt;
  assign w_VActNew = (w_HRise && r_LineAct && r_VAct != VMAX)
                   ? r_VAct + VW'(1) : r_VAct;
  assign w_NewSet  = {w_HTotNew, w_HActNew, w_VTotNew, w_VActNew};

  assign w_Sat     = w_HRise && (r_HCnt == HMAX || r_VCnt == VMAX);
  assign w_LineBad = w_HRise && !w_VRise && (r_HCnt != o_HTotal);
  assign w_TimeOut = (r_TO == TOMAX);
  assign w_Equal   = r_SnapOk && !r_Dirty && !w_Sat
                   && (w_NewSet == r_Snap);

  always_ff @(posedge i_VidClk or posedge i_Reset) begin
    if (i_Reset) begin
      r_HCnt    <= '0;
      r_HAct    <= '0;
      r_LineAct <= 1'b0;
      r_VCnt    <= '0;
      r_VAct    <= '0;
      r_TO      <= '0;
      o_HTotal  <= '0;
      o_HActive <= '0;
      o_VTotal  <= '0;
      o_VActive <= '0;
    end else begin
      if (w_HRise) begin
        r_HCnt    <= HW'(1);
        r_HAct    <= HW'(r_NB);
        r_LineAct <= r_NB;
        r_TO      <= '0;
        o_HTotal  <= r_HCnt;
        if (r_HAct != '0)
          o_HActive <= r_HAct;
      end else begin
        if (r_HCnt != HMAX)
          r_HCnt <= r_HCnt + HW'(1);
        if (r_NB && r_HAct != HMAX)
          r_HAct <= r_HAct + HW'(1);
        r_LineAct <= r_LineAct | r_NB;
        if (r_TO != TOMAX)
          r_TO <= r_TO + TW'(1);
      end
      if (w_VRise) begin
        r_VCnt    <= '0;
        r_VAct    <= '0;
        o_VTotal  <= w_VTotNew;
        o_VActive <= w_VActNew;
      end else begin
        r_VCnt <= w_VTotNew;
        r_VAct <= w_VActNew;
      end
    end
  end

  always_comb begin
    w_StateNxt = r_State;
    w_MatchNxt = r_Match;
    if (w_TimeOut) begin
      w_StateNxt = UNLOCKED;
      w_MatchNxt = '0;
    end else begin
      unique case (r_State)
        UNLOCKED: begin
          if (w_VRise) begin
            w_StateNxt = ACQUIRE;
            w_MatchNxt = '0;
          end
        end
        ACQUIRE: begin
          if (w_VRise) begin
            if (!w_Equal) begin
              w_MatchNxt = '0;
            end else if (int'(r_Match) + 2 >= LockFrames) begin
              w_StateNxt = LOCKED;
              w_MatchNxt = '0;
            end else begin
              w_MatchNxt = r_Match + MW'(1);
            end
          end
        end
        LOCKED: begin
          if ((w_VRise && !w_Equal) || w_LineBad) begin
            w_StateNxt = ACQUIRE;
            w_MatchNxt = '0;
          end
        end
        default: begin
          w_StateNxt = UNLOCKED;
          w_MatchNxt = '0;
        end
      endcase
    end
  end

  // Frames that lost lock or saturated never seed a lock comparison.
  always_ff @(posedge i_VidClk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State  <= UNLOCKED;
      r_Match  <= '0;
      r_Dirty  <= 1'b0;
      r_SnapOk <= 1'b0;
      r_Snap   <= '0;
    end else begin
      r_State <= w_StateNxt;
      r_Match <= w_MatchNxt;
      if (w_VRise) begin
        r_Dirty  <= 1'b0;
        r_Snap   <= w_NewSet;
        r_SnapOk <= (r_State != UNLOCKED) && !r_Dirty && !w_Sat;
      end else if (w_Sat || (w_LineBad && r_State == LOCKED)) begin
        r_Dirty <= 1'b1;
      end
    end
  end

  assign o_Locked     = (r_State == LOCKED);
  assign w_NextLocked = (w_StateNxt == LOCKED);
  assign w_Start      = w_NBRise && (r_First || w_VRise);
  assign w_X          = w_NBRise ? '0 : r_XCnt;
  assign w_Y          = w_Start  ? '0
                      : (w_NBRise && r_YCnt != VMAX) ? r_YCnt + VW'(1)
                      : r_YCnt;
  assign w_Valid      = r_NB && w_NextLocked && (r_Run || w_Start);

  always_ff @(posedge i_VidClk or posedge i_Reset) begin
    if (i_Reset) begin
      r_XCnt       <= '0;
      r_YCnt       <= '0;
      r_First      <= 1'b0;
      r_Run        <= 1'b0;
      o_PixValid   <= 1'b0;
      o_PixData    <= '0;
      o_PixX       <= '0;
      o_PixY       <= '0;
      o_FrameStart <= 1'b0;
      o_LineStart  <= 1'b0;
    end else begin
      if (r_NB)
        r_XCnt <= (w_X == HMAX) ? w_X : w_X + HW'(1);
      r_YCnt <= w_Y;
      if (w_VRise)
        r_First <= 1'b1;
      else if (w_NBRise)
        r_First <= 1'b0;
      r_Run        <= w_NextLocked && (r_Run || w_Start);
      o_PixValid   <= w_Valid;
      o_PixData    <= r_Rgb;
      o_PixX       <= w_X;
      o_PixY       <= w_Y;
      o_FrameStart <= w_Valid && w_Start;
      o_LineStart  <= w_Valid && w_NBRise;
    end
  end

endmodule

// File: tb/tb_vga_video_receiver.sv
// Directed bench for vga_video_receiver on a reduced 40x20 timing
// (24 active pixels, 12 active lines) with a frame-level pixel monitor.
module tb_vga_video_receiver;

  localparam int HT = 40;
  localparam int VT = 20;
  localparam int HA = 24;
  localparam int VA = 12;
  localparam int HB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs = 1'b0, vs = 1'b0, nb = 1'b0;
  logic [4:0] r = '0;
  logic [5:0] g = '0;
  logic [4:0] b = '0;

  logic        o_PixValid, o_FrameStart, o_LineStart, o_Locked;
  logic [15:0] o_PixData;
  logic [10:0] o_PixX, o_HTotal, o_HActive;
  logic [10:0] o_PixY, o_VTotal, o_VActive;

  int errs = 0;
  int checks = 0;
  int vcnt, perr, fs, ls;
  int hh[2], hl[2];
  bit hn[2];

  always #5 clk = ~clk;

  vga_video_receiver dut (
    .i_VidClk(clk), .i_Reset(rst),
    .i_HSync(hs), .i_VSync(vs), .i_nBlank(nb),
    .i_R(r), .i_G(g), .i_B(b),
    .o_PixValid(o_PixValid), .o_PixData(o_PixData),
    .o_PixX(o_PixX), .o_PixY(o_PixY),
    .o_FrameStart(o_FrameStart), .o_LineStart(o_LineStart),
    .o_Locked(o_Locked),
    .o_HTotal(o_HTotal), .o_HActive(o_HActive),
    .o_VTotal(o_VTotal), .o_VActive(o_VActive)
  );

  function automatic logic [15:0] pix(input int l, input int h);
    return 16'((l << 11) ^ (h * 1029) ^ 16'h5a3c);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    vcnt = 0; perr = 0; fs = 0; ls = 0;
  endtask

  task automatic tick(input logic h_s, input logic v_s, input logic n_b,
                      input int h, input int ln);
    logic [15:0] p;
    @(negedge clk);
    if (o_PixValid) begin
      vcnt++;
      if (!(hn[1] && int'(o_PixX) == hh[1] - HB && int'(o_PixY) == hl[1]
            && o_PixData == pix(hl[1], hh[1])))
        perr++;
    end
    if (o_FrameStart) begin
      fs++;
      if (o_PixX != 0 || o_PixY != 0) perr++;
    end
    if (o_LineStart) begin
      ls++;
      if (o_PixX != 0) perr++;
    end
    hh[1] = hh[0]; hl[1] = hl[0]; hn[1] = hn[0];
    hh[0] = h;     hl[0] = ln;    hn[0] = n_b;
    p = pix(ln, h);
    hs = h_s; vs = v_s; nb = n_b;
    r = p[15:11]; g = p[10:5]; b = p[4:0];
  endtask

  task automatic run_line(input int ln, input int len, input int voff,
                          input int hstop);
    for (int h = 0; h < len && h <= hstop; h++)
      tick(h < 4, (ln == 15 && h >= voff) || ln == 16,
           ln < VA && h >= HB && h < HB + HA, h, ln);
  endtask

  task automatic run_frame(input int bad, input int voff);
    clr_stats();
    for (int ln = 0; ln < VT; ln++)
      run_line(ln, (ln == bad) ? HT + 1 : HT, voff, 9999);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    hh = '{0, 0}; hl = '{0, 0}; hn = '{0, 0};
    clr_stats();
    repeat (3) @(negedge clk);
    chk("reset locked", o_Locked, 0);
    chk("reset valid", o_PixValid, 0);
    chk("reset htotal", o_HTotal, 0);
    chk("reset vtotal", o_VTotal, 0);
    rst = 1'b0;

    run_frame(-1, 10);
    chk("f0 locked", o_Locked, 0);
    run_frame(-1, 10);
    chk("f1 locked", o_Locked, 0);
    run_frame(-1, 10);
    chk("f2 locked at 3rd vsync", o_Locked, 1);
    chk("f2 no pixels", vcnt, 0);
    chk("htotal", o_HTotal, HT);
    chk("hactive", o_HActive, HA);
    chk("vtotal", o_VTotal, VT);
    chk("vactive", o_VActive, VA);

    run_frame(-1, 10);
    chk("f3 pixels", vcnt, HA * VA);
    chk("f3 coords", perr, 0);
    chk("f3 framestart", fs, 1);
    chk("f3 linestart", ls, VA);

    run_frame(5, 10);
    chk("f4 pixels until long line", vcnt, HA * 6);
    chk("f4 coords", perr, 0);
    chk("f4 unlocked", o_Locked, 0);
    run_frame(-1, 10);
    chk("f5 unlocked", o_Locked, 0);
    chk("f5 no pixels", vcnt, 0);
    run_frame(-1, 10);
    chk("f6 relocked", o_Locked, 1);
    run_frame(-1, 10);
    chk("f7 pixels", vcnt, HA * VA);
    chk("f7 coords", perr, 0);

    idle(1900);
    chk("hold below timeout", o_Locked, 1);
    idle(200);
    chk("hold past timeout", o_Locked, 0);

    run_frame(-1, 10);
    chk("f8 unlocked", o_Locked, 0);
    run_frame(-1, 10);
    chk("f9 unlocked", o_Locked, 0);
    run_frame(-1, 10);
    chk("f10 relocked", o_Locked, 1);

    clr_stats();
    for (int ln = 0; ln < 3; ln++) run_line(ln, HT, 10, 9999);
    run_line(3, HT, 10, HB + 10);
    #3;
    chk("pre-reset valid", o_PixValid, 1);
    chk("pre-reset x", o_PixX, 8);
    chk("pre-reset y", o_PixY, 3);
    rst = 1'b1;
    #1;
    chk("async valid", o_PixValid, 0);
    chk("async x", o_PixX, 0);
    chk("async y", o_PixY, 0);
    chk("async data", o_PixData, 0);
    chk("async locked", o_Locked, 0);
    chk("async htotal", o_HTotal, 0);
    chk("async vactive", o_VActive, 0);
    @(negedge clk);
    hs = 1'b0; vs = 1'b0; nb = 1'b0;
    hn = '{0, 0};
    rst = 1'b0;

    run_frame(-1, 10);
    chk("f12 unlocked", o_Locked, 0);
    run_frame(-1, 10);
    chk("f13 unlocked", o_Locked, 0);
    chk("f13 no pixels", vcnt, 0);
    run_frame(-1, 10);
    chk("f14 relocked", o_Locked, 1);
    chk("f14 no pixels", vcnt, 0);
    run_frame(-1, 10);
    chk("f15 pixels", vcnt, HA * VA);

    run_frame(-1, 0);
    chk("f16 vtotal same-cycle", o_VTotal, VT);
    chk("f16 locked", o_Locked, 1);
    chk("f16 pixels", vcnt, HA * VA);
    run_frame(-1, 10);
    chk("f17 vtotal", o_VTotal, VT);
    chk("f17 pixels", vcnt, HA * VA);
    chk("f17 coords", perr, 0);
    chk("f17 framestart", fs, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
